ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Completes the host side of the PS/2 link alongside the existing keyboard receiver and shares the same PS2_CLK and PS2_DATA pins.
- Drives both lines open-drain through active-high pull-low enables.
- Reports completion with a one-cycle done pulse plus ack and error flags, so the pong top can push LED or status commands.

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between the pong top and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, tx_done, tx_ack_ok, tx_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, tx_done, tx_ack_ok, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one command byte
// with odd parity, sample the device ack, and report done/ack/timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, RELEASE, DONE} state_t;

  state_t             state, state_d;
  logic [3:0]         bit_cnt, bit_d;
  logic [INH_W-1:0]   inh_cnt, inh_d;
  logic [TO_W-1:0]    to_cnt, to_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic               data_oe_q, doe_d;
  logic               ack_q, ack_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;

  logic [1:0]         clk_sync, data_sync;
  logic [1:0]         raw, filt;
  logic [FLT_W-1:0]   flt_cnt [2];
  logic               clk_prev;
  logic               fall, timed, timeout;

  // Index 0 is the clock line, index 1 the data line.
  assign raw = {data_sync[1], clk_sync[1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt      <= '1;
      clk_prev  <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          filt[i]    <= raw[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
        end
      end
    end
  end

  assign fall = clk_prev & ~filt[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_d;
      inh_cnt   <= inh_d;
      to_cnt    <= to_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_oe_q <= doe_d;
      ack_q     <= ack_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    inh_d   = inh_cnt;
    to_d    = to_cnt;
    shift_d = shift_q;
    par_d   = par_q;
    doe_d   = data_oe_q;
    ack_d   = ack_q;
    ok_d    = ok_q;
    err_d   = err_q;

    timed   = (state == SEND) || (state == ACK) || (state == RELEASE);
    timeout = timed && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    if (timed) to_d = (to_cnt == TO_W'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + TO_W'(1);

    // Timeout wins over a clock fall seen in the same cycle.
    if (timeout) begin
      doe_d   = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b1;
      state_d = DONE;
    end else begin
      case (state)
        IDLE: begin
          doe_d = 1'b0;
          if (tx.tx_valid) begin
            shift_d = tx.tx_data;
            par_d   = ~^tx.tx_data;
            inh_d   = '0;
            state_d = INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            doe_d   = 1'b1;
            state_d = RTS;
          end else begin
            inh_d = inh_cnt + INH_W'(1);
          end
        end
        RTS: begin
          bit_d   = '0;
          to_d    = '0;
          state_d = SEND;
        end
        SEND: begin
          if (fall) begin
            bit_d = bit_cnt + 4'd1;
            if (bit_d <= 4'd8) begin
              doe_d   = ~shift_q[0];
              shift_d = {1'b0, shift_q[7:1]};
            end else if (bit_d == 4'd9) begin
              doe_d = ~par_q;
            end else begin
              doe_d   = 1'b0;
              state_d = ACK;
            end
          end
        end
        ACK: begin
          if (fall) begin
            bit_d   = (bit_cnt == 4'd11) ? bit_cnt : bit_cnt + 4'd1;
            ack_d   = ~filt[1];
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (filt[0] && filt[1]) begin
            ok_d    = ack_q;
            err_d   = 1'b0;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign ps2_clk_oe   = (state == INHIBIT) || (state == RTS);
  assign ps2_data_oe  = data_oe_q;
  assign tx.tx_ready  = (state == IDLE);
  assign tx.busy      = (state != IDLE);
  assign tx.tx_done   = (state == DONE);
  assign tx.tx_ack_ok = ok_q;
  assign tx.tx_err    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, scoreboard of expected frames and status.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TMO = 3000;
  localparam int H   = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_pin, ps2_data_pin;
  int   cyc = 0, done_count = 0;
  int   n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic       ack_ok;
    logic       err;
  } exp_t;
  exp_t sb[$];

  ps2_host_tx_if tx_if ();

  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk & ~glitch;
  assign ps2_data_pin = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
    .clk(clk), .reset(reset), .tx(tx_if.slave),
    .ps2_clk_in(ps2_clk_pin), .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_if.tx_done) done_count <= done_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send_cmd(input logic [7:0] d);
    int n = 0;
    while (!tx_if.tx_ready && n < 50) begin @(negedge clk); n++; end
    check("ready_before_send", tx_if.tx_ready, 1);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic ack_ok, input logic err);
    exp_t e;
    e.data = d; e.ack_ok = ack_ok; e.err = err;
    sb.push_back(e);
  endtask

  // Measures the inhibit / request-to-send sequence; returns the cycle of clock release.
  task automatic check_rts(output int t_rel);
    int n = 0;
    while (!ps2_clk_oe && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < INH + 20) begin @(negedge clk); n++; end
    check("inhibit_len", n, INH);
    check("rts_both_low", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    check("clk_released_start_bit", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    t_rel = cyc;
  endtask

  // Device clocks 11 pulses, samples bit k on the rising edge after fall k.
  task automatic dev_frame(input bit do_ack, input int abort_fall, input bit do_glitch,
                           output logic [9:0] bits);
    bits = '0;
    for (int f = 1; f <= 11; f++) begin
      if (do_glitch && f == 3) begin
        repeat (H / 2) @(negedge clk);
        glitch = 1'b1;
        repeat (4) @(negedge clk);
        glitch = 1'b0;
        repeat (H / 2 - 4) @(negedge clk);
        check("glitch_bit_cnt", dut.bit_cnt, 2);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (f == abort_fall) begin
        repeat (20) @(negedge clk);
        check("pre_abort_data_oe", ps2_data_oe, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("abort_idle", tx_if.tx_ready, 1);
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        reset = 1'b1;
        return;
      end
      repeat (H) @(negedge clk);
      if (f <= 10) bits[f-1] = ps2_data_pin;
      dev_clk = 1'b1;
      if (f == 10 && do_ack) dev_data = 1'b0;
      if (f == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int limit, input logic [9:0] bits, input bit check_bits,
                           output int t_done);
    int n = 0;
    exp_t e;
    while (!tx_if.tx_done && n < limit) begin @(negedge clk); n++; end
    t_done = cyc;
    check("done_seen", tx_if.tx_done, 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("ack_ok", tx_if.tx_ack_ok, e.ack_ok);
    check("err", tx_if.tx_err, e.err);
    check("done_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("ready_low_at_done", tx_if.tx_ready, 0);
    if (check_bits) check("frame_bits", bits, {1'b1, ~^e.data, e.data});
    @(negedge clk);
    check("done_one_cycle", tx_if.tx_done, 0);
    check("ready_after_done", tx_if.tx_ready, 1);
    check("flags_hold", {tx_if.tx_ack_ok, tx_if.tx_err}, {e.ack_ok, e.err});
  endtask

  initial begin
    logic [9:0] bits;
    int t_rel, t_done, dc;

    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_if.busy, 0);
    check("rst_status", {tx_if.tx_done, tx_if.tx_ack_ok, tx_if.tx_err}, 3'b000);
    check("rst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with ack
    expect_frame(8'hED, 1'b1, 1'b0);
    send_cmd(8'hED);
    check("busy_after_accept", tx_if.busy, 1);
    check_rts(t_rel);
    dev_frame(1'b1, 0, 1'b0, bits);
    wait_done(300, bits, 1'b1, t_done);

    // 0xF4 without ack
    expect_frame(8'hF4, 1'b0, 1'b0);
    send_cmd(8'hF4);
    check_rts(t_rel);
    dev_frame(1'b0, 0, 1'b0, bits);
    wait_done(300, bits, 1'b1, t_done);

    // 0x00, device never clocks
    expect_frame(8'h00, 1'b0, 1'b1);
    send_cmd(8'h00);
    check_rts(t_rel);
    wait_done(TMO + 100, bits, 1'b0, t_done);
    check("timeout_latency", t_done - t_rel, TMO);

    // 0x00 with a 0xFF request during SEND that must be ignored
    expect_frame(8'h00, 1'b1, 1'b0);
    send_cmd(8'h00);
    check_rts(t_rel);
    dc = done_count;
    fork
      dev_frame(1'b1, 0, 1'b0, bits);
      begin
        repeat (200) @(negedge clk);
        tx_if.tx_data  = 8'hFF;
        tx_if.tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("ready_low_in_send", tx_if.tx_ready, 0);
        repeat (100) @(negedge clk);
        tx_if.tx_valid = 1'b0;
      end
    join
    wait_done(300, bits, 1'b1, t_done);
    repeat (20) @(negedge clk);
    check("single_done", done_count - dc, 1);
    check("ff_not_accepted", tx_if.busy, 0);

    // 0xA5 with a 4-cycle clock glitch before fall 3
    expect_frame(8'hA5, 1'b1, 1'b0);
    send_cmd(8'hA5);
    check_rts(t_rel);
    dev_frame(1'b1, 0, 1'b1, bits);
    wait_done(300, bits, 1'b1, t_done);

    // reset at fall 5 of 0xED, then 0xFF
    send_cmd(8'hED);
    check_rts(t_rel);
    dc = done_count;
    dev_frame(1'b1, 5, 1'b0, bits);
    repeat (30) @(negedge clk);
    check("no_done_after_abort", done_count - dc, 0);
    expect_frame(8'hFF, 1'b1, 1'b0);
    send_cmd(8'hFF);
    check_rts(t_rel);
    dev_frame(1'b1, 0, 1'b0, bits);
    wait_done(300, bits, 1'b1, t_done);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
